// File: rtl/fft_ctrl_pkg.sv
// Shared defaults and state encoding for the FFT sink-side controller.
// Constants are prefixed DEF_ so modules can reuse the plain names for their own parameters.
package fft_ctrl_pkg;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_PTS_W       = 11;
  localparam int DEF_FFT_PTS     = 1024;
  localparam int DEF_START_DELAY = 4;

  typedef enum logic {
    WAIT   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fft_sink_ctrl_if.sv
// Avalon-ST sink bus between this controller (master) and the FFT core (slave).
interface fft_sink_ctrl_if
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTS_W  = DEF_PTS_W
);

  // A beat transfers on a rising edge where sink_valid & sink_ready; readyLatency 0.
  // Once sink_valid is high, the master holds every beat field until that transfer.
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [1:0]        sink_error;
  logic              inverse;
  logic [DATA_W-1:0] outreal;
  logic [DATA_W-1:0] outimag;
  logic [PTS_W-1:0]  fft_pts;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_error, inverse,
           outreal, outimag, fft_pts,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_error, inverse,
           outreal, outimag, fft_pts,
    output sink_ready
  );

endinterface

// File: rtl/fft_frame_counter.sv
// Index of the beat currently presented within a frame; wraps from FFT_PTS-1 to 0.
module fft_frame_counter
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_PTS = DEF_FFT_PTS,
  parameter int PTS_W   = DEF_PTS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic [PTS_W-1:0] index,
  output logic             is_first,
  output logic             is_last
);

  localparam logic [PTS_W-1:0] LAST_IDX = PTS_W'(FFT_PTS - 1);

  logic [PTS_W-1:0] index_q;
  logic [PTS_W-1:0] index_d;

  always_comb begin
    index_d = index_q;
    if (advance) begin
      index_d = is_last ? '0 : index_q + PTS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign index    = index_q;
  assign is_first = (index_q == '0);
  assign is_last  = (index_q == LAST_IDX);

endmodule

// File: rtl/fft_sink_ctrl.sv
// Frames a free-running ADC sample stream into Avalon-ST beats for the FFT core.
// After a start delay it streams forever; stalls drop samples (no buffering).
module fft_sink_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PTS_W       = DEF_PTS_W,
  parameter int FFT_PTS     = DEF_FFT_PTS,
  parameter int START_DELAY = DEF_START_DELAY,
  parameter int OFFSET_BIN  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_W-1:0]    insignal,
  fft_sink_ctrl_if.master      sink,
  output state_e               dbg_state_o
);

  localparam logic [15:0]      DLY_LAST = 16'(START_DELAY - 1);
  localparam logic [PTS_W-1:0] PENULT   = PTS_W'(FFT_PTS - 2);

  state_e            state_q, state_d;
  logic [15:0]       dly_q, dly_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [DATA_W-1:0] real_q, real_d;
  logic [DATA_W-1:0] conv_sample;

  logic              advance;
  logic [PTS_W-1:0]  cnt_index;
  logic              cnt_first;
  logic              cnt_last;

  generate
    if (OFFSET_BIN != 0) begin : g_offset_bin
      assign conv_sample = {~insignal[DATA_W-1], insignal[DATA_W-2:0]};
    end else begin : g_passthru
      assign conv_sample = insignal;
    end
  endgenerate

  fft_frame_counter #(
    .FFT_PTS (FFT_PTS),
    .PTS_W   (PTS_W)
  ) u_frame_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (advance),
    .index    (cnt_index),
    .is_first (cnt_first),
    .is_last  (cnt_last)
  );

  // sop/eop are loaded for the beat about to be presented, so in STREAM they
  // look one index ahead of the counter (which tracks the presented beat).
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    real_d  = real_q;
    advance = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = STREAM;
          valid_d = 1'b1;
          sop_d   = cnt_first;
          eop_d   = cnt_last;
          real_d  = conv_sample;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      STREAM: begin
        if (sink.sink_ready) begin
          advance = 1'b1;
          sop_d   = cnt_last;
          eop_d   = (cnt_index == PENULT);
          real_d  = conv_sample;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT;
      dly_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      real_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      real_q  <= real_d;
    end
  end

  assign sink.sink_valid = valid_q;
  assign sink.sink_sop   = sop_q;
  assign sink.sink_eop   = eop_q;
  assign sink.outreal    = real_q;
  assign sink.outimag    = '0;
  assign sink.sink_error = 2'b00;
  assign sink.inverse    = 1'b0;
  assign sink.fft_pts    = PTS_W'(FFT_PTS);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fft_sink_ctrl.sv
// Bench for fft_sink_ctrl: start-up, framing, backpressure, conversion and mid-frame reset.
`timescale 1ns/1ps
module tb_fft_sink_ctrl;
  import fft_ctrl_pkg::*;

  localparam int DATA_W      = 12;
  localparam int PTS_W       = 11;
  localparam int FFT_PTS     = 1024;
  localparam int START_DELAY = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] insignal = '0;
  state_e            dbg_state;

  fft_sink_ctrl_if #(.DATA_W(DATA_W), .PTS_W(PTS_W)) sink_if ();

  fft_sink_ctrl #(
    .DATA_W      (DATA_W),
    .PTS_W       (PTS_W),
    .FFT_PTS     (FFT_PTS),
    .START_DELAY (START_DELAY),
    .OFFSET_BIN  (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .insignal    (insignal),
    .sink        (sink_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic m_valid;
  int   m_wait;
  int   m_idx;
  int   acc_total;
  int   sop_seen;
  int   eop_seen;
  logic stall_prev;
  logic [DATA_W-1:0] last_real;
  logic last_sop;
  logic last_eop;

  task automatic model_reset();
    exp_q.delete();
    m_valid    = 1'b0;
    m_wait     = 0;
    m_idx      = 0;
    stall_prev = 1'b0;
  endtask

  task automatic clear_stats();
    acc_total = 0;
    sop_seen  = 0;
    eop_seen  = 0;
  endtask

  // Drives one cycle of inputs, scores the beat on offer, then advances one edge.
  task automatic drive_cycle(input logic rdy, input logic [DATA_W-1:0] smp);
    logic [DATA_W-1:0] exp_real;
    sink_if.sink_ready = rdy;
    insignal = smp;
    checks++;
    if (sink_if.sink_valid !== m_valid) begin
      errors++;
      $display("FAIL valid_track: sink_valid=%b expected=%b (beat idx %0d)", sink_if.sink_valid, m_valid, m_idx);
    end
    if (stall_prev) begin
      checks++;
      if (sink_if.outreal !== last_real || sink_if.sink_sop !== last_sop || sink_if.sink_eop !== last_eop) begin
        errors++;
        $display("FAIL stall_hold: real/sop/eop=%h/%b/%b expected %h/%b/%b",
                 sink_if.outreal, sink_if.sink_sop, sink_if.sink_eop, last_real, last_sop, last_eop);
      end
    end
    if (m_valid && rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: beat accepted with outreal=%h but nothing expected", sink_if.outreal);
      end else begin
        exp_real = exp_q.pop_front();
        if (sink_if.outreal !== exp_real) begin
          errors++;
          $display("FAIL beat_data: outreal=%h expected=%h (beat idx %0d)", sink_if.outreal, exp_real, m_idx);
        end
      end
      checks++;
      if (sink_if.sink_sop !== (m_idx == 0)) begin
        errors++;
        $display("FAIL beat_sop: sop=%b expected=%b (beat idx %0d)", sink_if.sink_sop, (m_idx == 0), m_idx);
      end
      checks++;
      if (sink_if.sink_eop !== (m_idx == FFT_PTS - 1)) begin
        errors++;
        $display("FAIL beat_eop: eop=%b expected=%b (beat idx %0d)", sink_if.sink_eop, (m_idx == FFT_PTS - 1), m_idx);
      end
      checks++;
      if (sink_if.outimag !== '0) begin
        errors++;
        $display("FAIL beat_imag: outimag=%h expected=000", sink_if.outimag);
      end
      acc_total++;
      if (sink_if.sink_sop === 1'b1) sop_seen++;
      if (sink_if.sink_eop === 1'b1) eop_seen++;
      m_idx = (m_idx + 1) % FFT_PTS;
    end
    stall_prev = m_valid && !rdy;
    last_real  = sink_if.outreal;
    last_sop   = sink_if.sink_sop;
    last_eop   = sink_if.sink_eop;
    // Offset-binary to two's complement is a flip of the sign bit.
    if (!m_valid) begin
      if (m_wait == START_DELAY - 1) begin
        m_valid = 1'b1;
        exp_q.push_back(smp ^ 12'h800);
      end else begin
        m_wait++;
      end
    end else if (rdy) begin
      exp_q.push_back(smp ^ 12'h800);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    sink_if.sink_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      insignal = DATA_W'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
      checks++;
      if (sink_if.sink_valid !== 1'b0 || sink_if.outreal !== '0 || sink_if.sink_sop !== 1'b0 || sink_if.sink_eop !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: valid/sop/eop/real=%b/%b/%b/%h expected 0/0/0/000",
                 sink_if.sink_valid, sink_if.sink_sop, sink_if.sink_eop, sink_if.outreal);
      end
    end
    checks++;
    if (sink_if.outimag !== '0) begin
      errors++;
      $display("FAIL reset_imag: outimag=%h expected=000", sink_if.outimag);
    end
    checks++;
    if (sink_if.fft_pts !== 11'd1024) begin
      errors++;
      $display("FAIL reset_fft_pts: fft_pts=%0d expected=1024", sink_if.fft_pts);
    end
    checks++;
    if (sink_if.inverse !== 1'b0 || sink_if.sink_error !== 2'b00) begin
      errors++;
      $display("FAIL reset_const: inverse=%b error=%b expected 0/00", sink_if.inverse, sink_if.sink_error);
    end
    checks++;
    if (dbg_state !== WAIT) begin
      errors++;
      $display("FAIL reset_state: state=%0d expected=WAIT", dbg_state);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_startup();
    int first_edge;
    first_edge = 0;
    clear_stats();
    for (int n = 1; n <= 20; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
      if (sink_if.sink_valid === 1'b1) begin
        first_edge = n;
        break;
      end
    end
    checks++;
    if (first_edge != START_DELAY) begin
      errors++;
      $display("FAIL startup_delay: valid rose on edge %0d expected %0d", first_edge, START_DELAY);
    end
    checks++;
    if (sink_if.sink_sop !== 1'b1 || dbg_state !== STREAM) begin
      errors++;
      $display("FAIL startup_sop: sop=%b state=%0d expected 1/STREAM", sink_if.sink_sop, dbg_state);
    end
    for (int n = 0; n < FFT_PTS + 20 && eop_seen == 0; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    checks++;
    if (acc_total != FFT_PTS || sop_seen != 1 || eop_seen != 1) begin
      errors++;
      $display("FAIL startup_frame: beats=%0d sops=%0d eops=%0d expected 1024/1/1", acc_total, sop_seen, eop_seen);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int n = 0; n < 3 * FFT_PTS + 20 && eop_seen < 3; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    checks++;
    if (acc_total != 3 * FFT_PTS || sop_seen != 3 || eop_seen != 3) begin
      errors++;
      $display("FAIL b2b_frames: beats=%0d sops=%0d eops=%0d expected 3072/3/3", acc_total, sop_seen, eop_seen);
    end
    checks++;
    if (sink_if.sink_valid !== 1'b1 || sink_if.sink_sop !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_gap: valid=%b sop=%b after EOP expected 1/1", sink_if.sink_valid, sink_if.sink_sop);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held_real;
    logic held_sop;
    logic held_eop;
    clear_stats();
    for (int n = 0; n < FFT_PTS && acc_total < 500; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    held_real = sink_if.outreal;
    held_sop  = sink_if.sink_sop;
    held_eop  = sink_if.sink_eop;
    for (int n = 0; n < 3; n++) begin
      drive_cycle(1'b0, DATA_W'($urandom_range(0, 4095)));
    end
    checks++;
    if (sink_if.outreal !== held_real || sink_if.sink_sop !== held_sop || sink_if.sink_eop !== held_eop) begin
      errors++;
      $display("FAIL bp_stable: real/sop/eop=%h/%b/%b expected %h/%b/%b",
               sink_if.outreal, sink_if.sink_sop, sink_if.sink_eop, held_real, held_sop, held_eop);
    end
    for (int n = 0; n < FFT_PTS + 20 && eop_seen == 0; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    checks++;
    if (acc_total != FFT_PTS || sop_seen != 1 || eop_seen != 1) begin
      errors++;
      $display("FAIL bp_frame: beats=%0d sops=%0d eops=%0d expected 1024/1/1", acc_total, sop_seen, eop_seen);
    end
  endtask

  task automatic test_conversion();
    logic [DATA_W-1:0] conv_in [3];
    logic [DATA_W-1:0] conv_out[3];
    conv_in[0] = 12'h800; conv_out[0] = 12'h000;
    conv_in[1] = 12'hFFF; conv_out[1] = 12'h7FF;
    conv_in[2] = 12'h000; conv_out[2] = 12'h800;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, conv_in[i]);
      checks++;
      if (sink_if.outreal !== conv_out[i] || sink_if.outimag !== '0) begin
        errors++;
        $display("FAIL conv_%0d: in=%h outreal=%h outimag=%h expected %h/000",
                 i, conv_in[i], sink_if.outreal, sink_if.outimag, conv_out[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_edge;
    first_edge = 0;
    for (int n = 0; n < 2 * FFT_PTS && m_idx != 300; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sink_if.sink_valid !== 1'b0 || sink_if.sink_sop !== 1'b0 || sink_if.sink_eop !== 1'b0 ||
        sink_if.outreal !== '0 || dbg_state !== WAIT) begin
      errors++;
      $display("FAIL midreset_clear: valid/sop/eop/real/state=%b/%b/%b/%h/%0d expected 0/0/0/000/WAIT",
               sink_if.sink_valid, sink_if.sink_sop, sink_if.sink_eop, sink_if.outreal, dbg_state);
    end
    for (int n = 0; n < 3; n++) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    clear_stats();
    for (int n = 1; n <= 20; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
      if (sink_if.sink_valid === 1'b1) begin
        first_edge = n;
        break;
      end
    end
    checks++;
    if (first_edge != START_DELAY || sink_if.sink_sop !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: valid edge=%0d sop=%b expected %0d/1", first_edge, sink_if.sink_sop, START_DELAY);
    end
    for (int n = 0; n < FFT_PTS + 20 && eop_seen == 0; n++) begin
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 4095)));
    end
    checks++;
    if (acc_total != FFT_PTS || sop_seen != 1 || eop_seen != 1) begin
      errors++;
      $display("FAIL midreset_frame: beats=%0d sops=%0d eops=%0d expected 1024/1/1", acc_total, sop_seen, eop_seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sink_if.sink_ready = 1'b0;
    model_reset();
    clear_stats();
    @(posedge clk);
    #1;
    test_reset();
    test_startup();
    test_back_to_back();
    test_backpressure();
    test_conversion();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
